// File: rtl/de_pkg.sv
// ============================================================================
//  Module      : de_pkg
//  Description : Shared decode-stage types: operation classes, RV32I opcodes,
//                DE latch layout and register-file / scoreboard sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package de_pkg;

    localparam int DE_DBITS  = 32;
    localparam int DE_NREGS  = 32;
    localparam int DE_SBBITS = 2;

    typedef enum logic [3:0] {
        OP_OP      = 4'd0,
        OP_OPIMM   = 4'd1,
        OP_LOAD    = 4'd2,
        OP_STORE   = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_JAL     = 4'd5,
        OP_JALR    = 4'd6,
        OP_LUI     = 4'd7,
        OP_AUIPC   = 4'd8,
        OP_ILLEGAL = 4'd9
    } de_op_e;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    // DE latch, MSB first in this field order
    typedef struct packed {
        logic                valid;
        logic [DE_DBITS-1:0] pc;
        de_op_e              op;
        logic [3:0]          funct;
        logic [4:0]          rd;
        logic                wr_reg;
        logic [DE_DBITS-1:0] rs1_val;
        logic [DE_DBITS-1:0] rs2_val;
        logic [DE_DBITS-1:0] imm;
        logic                illegal;
    } de_latch_t;

endpackage

`default_nettype wire

// File: rtl/de_if.sv
// ============================================================================
//  Module      : de_if
//  Description : Fetch-latch, writeback, flush and DE-latch bundle around the
//                decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface de_if
    import de_pkg::*;
#(
    parameter int DBITS = DE_DBITS
);
    logic             fe_valid;
    logic [31:0]      fe_inst;
    logic [DBITS-1:0] fe_pc;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [DBITS-1:0] wb_data;
    logic             agex_flush;
    logic             stall_to_fe;
    logic             de_valid;
    logic [DBITS-1:0] de_pc;
    de_op_e           de_op;
    logic [3:0]       de_funct;
    logic [4:0]       de_rd;
    logic             de_wr_reg;
    logic [DBITS-1:0] de_rs1_val;
    logic [DBITS-1:0] de_rs2_val;
    logic [DBITS-1:0] de_imm;
    logic             de_illegal;

    modport master (
        output fe_valid, fe_inst, fe_pc, wb_we, wb_rd, wb_data, agex_flush,
        input  stall_to_fe, de_valid, de_pc, de_op, de_funct, de_rd, de_wr_reg,
               de_rs1_val, de_rs2_val, de_imm, de_illegal
    );

    modport slave (
        input  fe_valid, fe_inst, fe_pc, wb_we, wb_rd, wb_data, agex_flush,
        output stall_to_fe, de_valid, de_pc, de_op, de_funct, de_rd, de_wr_reg,
               de_rs1_val, de_rs2_val, de_imm, de_illegal
    );
endinterface

`default_nettype wire

// File: rtl/de_scoreboard.sv
// ============================================================================
//  Module      : de_scoreboard
//  Description : Per-register in-flight write counters with summed inc/dec
//                arbitration and hazard query ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module de_scoreboard
    import de_pkg::*;
#(
    parameter int NREGS  = DE_NREGS,
    parameter int SBBITS = DE_SBBITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_en,
    input  logic [4:0] inc_rd,
    input  logic       wb_dec_en,
    input  logic [4:0] wb_dec_rd,
    input  logic       fl_dec_en,
    input  logic [4:0] fl_dec_rd,
    input  logic [4:0] q_rs1,
    input  logic [4:0] q_rs2,
    input  logic [4:0] q_rd,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_full
);

    localparam logic [SBBITS-1:0] C_CNT_MAX = '1;

    logic [SBBITS-1:0] cnt_q [NREGS];
    logic [SBBITS-1:0] cnt_d [NREGS];

    // Each counter adds all of its same-cycle events; x0 is pinned at zero.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i]
                     + SBBITS'(inc_en    && (inc_rd    == 5'(i)))
                     - SBBITS'(wb_dec_en && (wb_dec_rd == 5'(i)))
                     - SBBITS'(fl_dec_en && (fl_dec_rd == 5'(i)));
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rs1_busy = (cnt_q[q_rs1] != '0);
    assign rs2_busy = (cnt_q[q_rs2] != '0);
    assign rd_full  = (cnt_q[q_rd] == C_CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/de_stage.sv
// ============================================================================
//  Module      : de_stage
//  Description : RV32I decode stage: field/immediate decode, register file,
//                RAW-hazard stall and the DE pipeline latch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module de_stage
    import de_pkg::*;
#(
    parameter int DBITS  = DE_DBITS,
    parameter int NREGS  = DE_NREGS,
    parameter int SBBITS = DE_SBBITS
) (
    input  logic clk,
    input  logic reset,
    de_if.slave  bus
);

    logic [31:0]      inst;
    logic [4:0]       rs1, rs2, rd;
    logic [DBITS-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    de_op_e           op;
    logic [DBITS-1:0] imm;
    logic             rs1_used, rs2_used, wr_reg;
    logic             rs1_busy, rs2_busy, rd_full, hazard, accept;
    logic [DBITS-1:0] rs1_val, rs2_val;
    logic [DBITS-1:0] regs_q [NREGS];
    logic [DBITS-1:0] regs_d [NREGS];
    de_latch_t        de_q, de_d;

    assign inst = bus.fe_inst;
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];
    assign rd   = inst[11:7];

    assign imm_i = {{(DBITS-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(DBITS-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(DBITS-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{(DBITS-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u = DBITS'($signed({inst[31:12], 12'b0}));

    always_comb begin
        op  = OP_ILLEGAL;
        imm = '0;
        case (inst[6:0])
            c_opc_op:     op = OP_OP;
            c_opc_op_imm: begin op = OP_OPIMM;  imm = imm_i; end
            c_opc_load:   begin op = OP_LOAD;   imm = imm_i; end
            c_opc_store:  begin op = OP_STORE;  imm = imm_s; end
            c_opc_branch: begin op = OP_BRANCH; imm = imm_b; end
            c_opc_jal:    begin op = OP_JAL;    imm = imm_j; end
            c_opc_jalr:   begin op = OP_JALR;   imm = imm_i; end
            c_opc_lui:    begin op = OP_LUI;    imm = imm_u; end
            c_opc_auipc:  begin op = OP_AUIPC;  imm = imm_u; end
            default:      op = OP_ILLEGAL;
        endcase
        rs1_used = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
        rs2_used = op inside {OP_OP, OP_STORE, OP_BRANCH};
        wr_reg   = (op inside {OP_OP, OP_OPIMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})
                   && (rd != 5'd0);
    end

    // Reads see a same-cycle writeback; x0 always reads zero.
    always_comb begin
        rs1_val = regs_q[rs1];
        if (bus.wb_we && (bus.wb_rd == rs1)) rs1_val = bus.wb_data;
        if (rs1 == 5'd0) rs1_val = '0;
        rs2_val = regs_q[rs2];
        if (bus.wb_we && (bus.wb_rd == rs2)) rs2_val = bus.wb_data;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    always_comb begin
        regs_d = regs_q;
        if (bus.wb_we && (bus.wb_rd != 5'd0)) regs_d[bus.wb_rd] = bus.wb_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    de_scoreboard #(
        .NREGS  (NREGS),
        .SBBITS (SBBITS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .inc_en    (accept && wr_reg),
        .inc_rd    (rd),
        .wb_dec_en (bus.wb_we),
        .wb_dec_rd (bus.wb_rd),
        .fl_dec_en (bus.agex_flush && de_q.valid && de_q.wr_reg),
        .fl_dec_rd (de_q.rd),
        .q_rs1     (rs1),
        .q_rs2     (rs2),
        .q_rd      (rd),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rd_full   (rd_full)
    );

    assign hazard = (rs1_used && rs1_busy) || (rs2_used && rs2_busy) || (wr_reg && rd_full);
    assign accept = bus.fe_valid && !bus.agex_flush && !hazard;
    assign bus.stall_to_fe = reset && bus.fe_valid && !bus.agex_flush && hazard;

    always_comb begin
        de_d = '0;
        if (accept) begin
            de_d.valid   = 1'b1;
            de_d.pc      = bus.fe_pc;
            de_d.op      = op;
            de_d.funct   = {inst[30], inst[14:12]};
            de_d.rd      = rd;
            de_d.wr_reg  = wr_reg;
            de_d.rs1_val = rs1_val;
            de_d.rs2_val = rs2_val;
            de_d.imm     = imm;
            de_d.illegal = (op == OP_ILLEGAL);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) de_q <= '0;
        else        de_q <= de_d;
    end

    assign bus.de_valid   = de_q.valid;
    assign bus.de_pc      = de_q.pc;
    assign bus.de_op      = de_q.op;
    assign bus.de_funct   = de_q.funct;
    assign bus.de_rd      = de_q.rd;
    assign bus.de_wr_reg  = de_q.wr_reg;
    assign bus.de_rs1_val = de_q.rs1_val;
    assign bus.de_rs2_val = de_q.rs2_val;
    assign bus.de_imm     = de_q.imm;
    assign bus.de_illegal = de_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_de_stage.sv
// ============================================================================
//  Module      : tb_de_stage
//  Description : Directed and randomized bench for de_stage against a
//                behavioural register-file / in-flight-count model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_de_stage;
    import de_pkg::*;

    logic clk;
    logic reset;
    de_if #(.DBITS(32)) bus ();

    de_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  op;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic        ill;
    } lat_t;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    lat_t        m_lat;
    logic        m_stall;
    int          n_tests, n_fail, stall_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] in, output logic [3:0] op,
                                       output logic [31:0] imm, output logic u1,
                                       output logic u2, output logic wr);
        int s;
        s = 0;
        case (in[6:0])
            7'h33:   op = OP_OP;
            7'h13:   op = OP_OPIMM;
            7'h03:   op = OP_LOAD;
            7'h23:   op = OP_STORE;
            7'h63:   op = OP_BRANCH;
            7'h6F:   op = OP_JAL;
            7'h67:   op = OP_JALR;
            7'h37:   op = OP_LUI;
            7'h17:   op = OP_AUIPC;
            default: op = OP_ILLEGAL;
        endcase
        if (op == OP_OPIMM || op == OP_LOAD || op == OP_JALR) begin
            s = int'(in[31:20]);
            if (s >= 2048) s -= 4096;
        end else if (op == OP_STORE) begin
            s = int'({in[31:25], in[11:7]});
            if (s >= 2048) s -= 4096;
        end else if (op == OP_BRANCH) begin
            s = 2 * int'({in[31], in[7], in[30:25], in[11:8]});
            if (s >= 4096) s -= 8192;
        end else if (op == OP_JAL) begin
            s = 2 * int'({in[31], in[19:12], in[20], in[30:21]});
            if (s >= (1 << 20)) s -= (1 << 21);
        end
        imm = 32'(s);
        if (op == OP_LUI || op == OP_AUIPC) imm = in & 32'hFFFF_F000;
        u1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        u2 = (op == OP_OP || op == OP_STORE || op == OP_BRANCH);
        wr = !(op == OP_STORE || op == OP_BRANCH || op == OP_ILLEGAL) && (in[11:7] != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wdat);
        if (r == 5'd0) return 32'd0;
        if (we && wrd == r) return wdat;
        return m_regs[r];
    endfunction

    // One clock: drive at negedge, check the combinational stall, advance the
    // model, then check the DE latch just after the rising edge.
    task automatic step(input logic rst_n, input logic fv, input logic [31:0] inst,
                        input logic [31:0] pc, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wdat, input logic fl);
        logic [3:0]  op;
        logic [31:0] imm;
        logic        u1, u2, wr, haz, full;
        logic [4:0]  rs1, rs2, rd;
        lat_t        nl;
        @(negedge clk);
        reset          = rst_n;
        bus.fe_valid   = fv;
        bus.fe_inst    = inst;
        bus.fe_pc      = pc;
        bus.wb_we      = we;
        bus.wb_rd      = wrd;
        bus.wb_data    = wdat;
        bus.agex_flush = fl;
        #1;
        ref_decode(inst, op, imm, u1, u2, wr);
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        rd  = inst[11:7];
        haz = fv && !fl && ((u1 && m_cnt[rs1] != 0) || (u2 && m_cnt[rs2] != 0)
                            || (wr && m_cnt[rd] == 3));
        m_stall = rst_n && haz;
        check("stall_to_fe", 32'(bus.stall_to_fe), 32'(m_stall));
        if (bus.stall_to_fe) stall_seen++;
        nl = '0;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_cnt[i]  = 0;
                m_regs[i] = 32'd0;
            end
        end else begin
            if (fv && !fl && !haz) begin
                nl.valid = 1'b1;
                nl.pc    = pc;
                nl.op    = op;
                nl.funct = {inst[30], inst[14:12]};
                nl.rd    = rd;
                nl.wr    = wr;
                nl.rs1v  = m_read(rs1, we, wrd, wdat);
                nl.rs2v  = m_read(rs2, we, wrd, wdat);
                nl.imm   = imm;
                nl.ill   = (op == OP_ILLEGAL);
                if (wr) m_cnt[rd]++;
            end
            if (we && wrd != 5'd0) begin
                m_cnt[wrd]--;
                m_regs[wrd] = wdat;
            end
            if (fl && m_lat.valid && m_lat.wr) m_cnt[m_lat.rd]--;
        end
        m_lat = nl;
        full  = !rst_n || nl.valid;
        @(posedge clk);
        #1;
        check("de_valid", 32'(bus.de_valid), 32'(m_lat.valid));
        if (full) begin
            check("de_pc",      bus.de_pc,              m_lat.pc);
            check("de_op",      32'(bus.de_op),         32'(m_lat.op));
            check("de_funct",   32'(bus.de_funct),      32'(m_lat.funct));
            check("de_rd",      32'(bus.de_rd),         32'(m_lat.rd));
            check("de_wr_reg",  32'(bus.de_wr_reg),     32'(m_lat.wr));
            check("de_rs1_val", bus.de_rs1_val,         m_lat.rs1v);
            check("de_rs2_val", bus.de_rs2_val,         m_lat.rs2v);
            check("de_imm",     bus.de_imm,             m_lat.imm);
            check("de_illegal", 32'(bus.de_illegal),    32'(m_lat.ill));
        end
    endtask

    task automatic fe(input logic [31:0] inst);
        step(1'b1, 1'b1, inst, 32'h0000_0100, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, r, d, 1'b0);
    endtask

    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                              7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    initial begin
        logic [31:0] cur_inst, cur_pc, wdat;
        logic        cur_v, fl, we, rst_n;
        logic [4:0]  wrd;
        int          r, avail, base;

        n_tests = 0; n_fail = 0; stall_seen = 0;
        m_stall = 1'b0; m_lat = '0;
        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0; m_regs[i] = 32'd0;
        end
        reset = 1'b0;
        bus.fe_valid = 1'b0; bus.fe_inst = 32'd0; bus.fe_pc = 32'd0;
        bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0; bus.agex_flush = 1'b0;

        step(1'b0, 1'b1, 32'h0010_8133, 32'h40, 1'b1, 5'd3, 32'h55, 1'b1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);

        // addi x1,x0,5 then three independent instructions
        stall_seen = 0;
        fe(32'h0050_0093);
        check("t1_imm", bus.de_imm, 32'd5);
        check("t1_wr",  32'(bus.de_wr_reg), 32'd1);
        check("t1_rd",  32'(bus.de_rd), 32'd1);
        fe(32'h0010_0313);
        fe(32'h0020_0393);
        fe(32'h0000_1437);
        check("t1_nostall", 32'(stall_seen), 32'd0);
        wb(5'd1, 32'h11); wb(5'd6, 32'h66); wb(5'd7, 32'h77); wb(5'd8, 32'h88);

        // RAW on x1: three stall cycles, WB on the third
        fe(32'h0050_0093);
        stall_seen = 0;
        fe(32'h0010_8133);
        fe(32'h0010_8133);
        step(1'b1, 1'b1, 32'h0010_8133, 32'h100, 1'b1, 5'd1, 32'd5, 1'b0);
        fe(32'h0010_8133);
        check("t2_stalls", 32'(stall_seen), 32'd3);
        check("t2_rs1", bus.de_rs1_val, 32'd5);
        check("t2_rs2", bus.de_rs2_val, 32'd5);
        wb(5'd2, 32'd10);

        // branch immediate
        fe(32'hFE00_0EE3);
        check("t3_op",  32'(bus.de_op), 32'(OP_BRANCH));
        check("t3_wr",  32'(bus.de_wr_reg), 32'd0);
        check("t3_imm", bus.de_imm, 32'hFFFF_FFFC);

        // flush drops the wrong-path addi x3
        fe(32'h0070_0193);
        step(1'b1, 1'b1, 32'h0031_8233, 32'h104, 1'b0, 5'd0, 32'd0, 1'b1);
        check("t4_bubble", 32'(bus.de_valid), 32'd0);
        stall_seen = 0;
        fe(32'h0031_8233);
        check("t4_nostall", 32'(stall_seen), 32'd0);
        wb(5'd4, 32'h44);

        // counter saturation on x5
        stall_seen = 0;
        fe(32'h0010_0293); fe(32'h0010_0293); fe(32'h0010_0293);
        fe(32'h0010_0293); fe(32'h0010_0293);
        step(1'b1, 1'b1, 32'h0010_0293, 32'h100, 1'b1, 5'd5, 32'h5, 1'b0);
        fe(32'h0010_0293);
        check("t5_stalls", 32'(stall_seen), 32'd3);
        wb(5'd5, 32'h5); wb(5'd5, 32'h5); wb(5'd5, 32'h5);

        // lui x0 and an unknown opcode
        fe(32'h0000_1037);
        check("t6_lui_wr", 32'(bus.de_wr_reg), 32'd0);
        fe(32'h0000_007F);
        check("t6_ill",   32'(bus.de_illegal), 32'd1);
        check("t6_valid", 32'(bus.de_valid), 32'd1);
        stall_seen = 0;
        fe(32'h0000_04B3);
        check("t6_nostall", 32'(stall_seen), 32'd0);
        wb(5'd9, 32'h9);

        // reset while stalled discards tracking
        fe(32'h0050_0093);
        fe(32'h0010_8133);
        step(1'b0, 1'b1, 32'h0010_8133, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0);
        stall_seen = 0;
        fe(32'h0010_8133);
        check("t7_nostall", 32'(stall_seen), 32'd0);
        wb(5'd2, 32'h2);

        // randomized traffic
        cur_inst = 32'd0; cur_v = 1'b0; cur_pc = 32'h1000;
        for (int c = 0; c < 800; c++) begin
            rst_n = !(c >= 400 && c < 402);
            if (!m_stall) begin
                cur_inst        = $urandom;
                cur_inst[6:0]   = opcs[$urandom_range(0, 9)];
                cur_inst[11:7]  = 5'($urandom_range(0, 7));
                cur_inst[19:15] = 5'($urandom_range(0, 7));
                cur_inst[24:20] = 5'($urandom_range(0, 7));
                cur_v           = ($urandom_range(0, 7) != 0);
                cur_pc          = cur_pc + 32'd4;
            end
            fl = ($urandom_range(0, 11) == 0);
            we = 1'b0; wrd = 5'd0; wdat = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                r     = $urandom_range(1, 7);
                base  = (fl && m_lat.valid && m_lat.wr && m_lat.rd == 5'(r)) ? 1 : 0;
                avail = m_cnt[r] - base;
                if (avail > 0) begin
                    we = 1'b1; wrd = 5'(r);
                end
            end else if ($urandom_range(0, 19) == 0) begin
                we = 1'b1;
            end
            step(rst_n, cur_v, cur_inst, cur_pc, we, wrd, wdat, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
